// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory signals of the boot loader.
// The master drives the stream (start/in_byte/in_valid); the slave is the loader.
interface instr_loader_if;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;
    logic [2:0]  dbg_state;

    // Valid/ready: a byte moves on a rising edge where in_valid && in_ready;
    // in_ready depends on loader state only, never on in_valid.
    modport master (
        output start, in_byte, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy,
               error, err_code, words_loaded, dbg_state
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy,
               error, err_code, words_loaded, dbg_state
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: receives a counted, XOR-checksummed byte frame, packs big-endian
// words into instruction memory and raises cpu_run once the image verifies.
module instr_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 1024
) (
    input  logic           CLK,
    input  logic           RST_N,
    instr_loader_if.slave  bus
);
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_count;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic [7:0]    r_csum;
    logic [TW-1:0] r_idle_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [15:0]   r_words_loaded;
    logic [1:0]    r_err_code;
    logic          w_in_ready;
    logic          w_start_load;
    logic [1:0]    w_err;
    logic          w_accept;
    logic [15:0]   w_hdr_count;

    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_hdr_count = {r_count[15:8], bus.in_byte};

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_err        = 2'b00;
        w_in_ready   = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    w_next       = S_HDR_HI;
                    w_start_load = 1'b1;
                end
            end
            S_HDR_HI: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_hdr_count != 16'd0 && w_hdr_count <= DEPTH_W) begin
                        w_next = S_DATA;
                    end else begin
                        w_next = S_ERROR;
                        w_err  = 2'b01;
                    end
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_byte_idx == 2'd3 && r_words_loaded == r_count - 16'd1)
                    w_next = S_CSUM;
            end
            S_CSUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_byte == r_csum) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ERROR;
                        w_err  = 2'b10;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        // The stream-receiving states are exactly the ones the idle timer guards.
        if (w_in_ready && !bus.in_valid && r_idle_cnt == TO_LAST) begin
            w_next = S_ERROR;
            w_err  = 2'b11;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count        <= '0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_csum         <= '0;
            r_idle_cnt     <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_words_loaded <= '0;
            r_err_code     <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_load) begin
                r_count        <= '0;
                r_byte_idx     <= '0;
                r_word         <= '0;
                r_csum         <= '0;
                r_words_loaded <= '0;
                r_err_code     <= '0;
            end
            if (w_err != 2'b00) r_err_code <= w_err;
            if (w_in_ready && !bus.in_valid) r_idle_cnt <= r_idle_cnt + TW'(1);
            else                             r_idle_cnt <= '0;
            if (w_accept) begin
                case (r_state)
                    S_HDR_HI: r_count[15:8] <= bus.in_byte;
                    S_HDR_LO: r_count[7:0]  <= bus.in_byte;
                    S_DATA: begin
                        r_word     <= {r_word[23:0], bus.in_byte};
                        r_csum     <= r_csum ^ bus.in_byte;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // words_loaded doubles as the index of the word being completed
                        if (r_byte_idx == 2'd3) begin
                            r_we           <= 1'b1;
                            r_wdata        <= {r_word[23:0], bus.in_byte};
                            r_addr         <= BASE_ADDR + {14'd0, r_words_loaded, 2'b00};
                            r_words_loaded <= r_words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = w_in_ready;
    assign bus.cpu_run      = (r_state == S_DONE);
    assign bus.error        = (r_state == S_ERROR);
    assign bus.err_code     = r_err_code;
    assign bus.imem_we      = r_we;
    assign bus.imem_addr    = r_addr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.words_loaded = r_words_loaded;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized frames against a frame-level
// model (expected writes, checksum, final status) plus directed corner cases.
module tb_instr_loader;
  localparam int          DEPTH   = 64;
  localparam int          TIMEOUT = 1024;
  localparam logic [31:0] BASE    = 32'h0;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  instr_loader_if bus();

  instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stalls = 0;

  always @(posedge CLK) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] tx_words[$];

  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) begin
      obs_q.push_back({bus.imem_addr, bus.imem_wdata});
      obs_cyc.push_back(cyc);
    end
  end

  // reference model: checksum is the XOR of every data byte of the image
  function automatic logic [7:0] model_csum(input int count);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < count; i++)
      c = c ^ tx_words[i][31:24] ^ tx_words[i][23:16] ^ tx_words[i][15:8] ^ tx_words[i][7:0];
    return c;
  endfunction

  function automatic bit count_ok(input int count);
    return (count >= 1) && (count <= DEPTH);
  endfunction

  task automatic build_exp(input int count);
    exp_q.delete();
    if (count_ok(count))
      for (int i = 0; i < count; i++) exp_q.push_back({BASE + 32'(4 * i), tx_words[i]});
  endtask

  task automatic random_words(input int count);
    tx_words.delete();
    for (int i = 0; i < count; i++) tx_words.push_back($urandom);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic drop_valid();
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int waited = 0;
    if (gap > 0) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      repeat (gap - 1) @(negedge CLK);
    end
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    stalls += waited;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      ok = 1'b0;
      $display("FAIL send_byte: in_ready=%b after 50 cycles, required 1", bus.in_ready);
    end else begin
      ok = 1'b1;
      @(posedge CLK);
    end
  endtask

  // header, then data and checksum only when the count is legal
  task automatic send_frame(input int count, input logic [7:0] csum_byte, input int gap_max);
    bit ok;
    logic [15:0] c16;
    logic [31:0] w;
    c16 = 16'(count);
    obs_q.delete();
    obs_cyc.delete();
    pulse_start();
    send_byte(c16[15:8], $urandom_range(0, gap_max), ok);
    if (!ok) return;
    send_byte(c16[7:0], $urandom_range(0, gap_max), ok);
    if (!ok) return;
    if (count_ok(count)) begin
      for (int i = 0; i < count; i++) begin
        w = tx_words[i];
        for (int k = 0; k < 4; k++) begin
          send_byte(w[31 - 8 * k -: 8], $urandom_range(0, gap_max), ok);
          if (!ok) return;
        end
      end
      send_byte(csum_byte, $urandom_range(0, gap_max), ok);
    end
    drop_valid();
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL reset imem_we: got %b want 0", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset imem_addr: got %h want 0", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset imem_wdata: got %h want 0", bus.imem_wdata); end
    n_cmp++; if (bus.cpu_run !== 1'b0) begin n_bad++; $display("FAIL reset cpu_run: got %b want 0", bus.cpu_run); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset error: got %b want 0", bus.error); end
    n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL reset err_code: got %b want 00", bus.err_code); end
    n_cmp++; if (bus.words_loaded !== 16'd0) begin n_bad++; $display("FAIL reset words_loaded: got %0d want 0", bus.words_loaded); end
  endtask

  // known image, its corrupted-checksum twin, then randomized frames incl. 1 and DEPTH words
  task automatic test_frames();
    int count;
    logic [7:0] good, sent;
    bit exp_ok;
    for (int s = 0; s < 9; s++) begin
      if (s < 2) begin
        count = 2;
        tx_words.delete();
        tx_words.push_back(32'h20080005);
        tx_words.push_back(32'h2009000A);
      end else begin
        count = (s == 2) ? 1 : (s == 3) ? DEPTH : $urandom_range(1, 8);
        random_words(count);
      end
      good = model_csum(count);
      if (s == 1)      sent = 8'h00;
      else if (s == 0) sent = good;
      else             sent = ($urandom_range(0, 3) == 0) ? (good ^ (8'h01 << $urandom_range(0, 7))) : good;
      exp_ok = (sent == good);
      build_exp(count);
      send_frame(count, sent, (s < 2) ? 0 : 3);
      n_cmp++; if (bus.cpu_run !== exp_ok) begin n_bad++; $display("FAIL frame%0d cpu_run: got %b want %b", s, bus.cpu_run, exp_ok); end
      n_cmp++; if (bus.error !== !exp_ok) begin n_bad++; $display("FAIL frame%0d error: got %b want %b", s, bus.error, !exp_ok); end
      n_cmp++; if (bus.err_code !== (exp_ok ? 2'b00 : 2'b10)) begin n_bad++; $display("FAIL frame%0d err_code: got %b want %b", s, bus.err_code, exp_ok ? 2'b00 : 2'b10); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL frame%0d busy: got %b want 0", s, bus.busy); end
      n_cmp++; if (bus.words_loaded !== 16'(count)) begin n_bad++; $display("FAIL frame%0d words_loaded: got %0d want %0d", s, bus.words_loaded, count); end
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL frame%0d write_count: got %0d want %0d", s, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL frame%0d write%0d: got addr %h data %h want addr %h data %h", s, i,
                   obs_q[i][63:32], obs_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
        end
      end
    end
  endtask

  task automatic test_bad_count();
    int counts[3] = '{0, DEPTH + 1, 16'h0101};
    for (int i = 0; i < 3; i++) begin
      send_frame(counts[i], 8'h00, 1);
      n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL badcnt%0d error: got %b want 1", counts[i], bus.error); end
      n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL badcnt%0d err_code: got %b want 01", counts[i], bus.err_code); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL badcnt%0d in_ready: got %b want 0", counts[i], bus.in_ready); end
      n_cmp++; if (bus.cpu_run !== 1'b0) begin n_bad++; $display("FAIL badcnt%0d cpu_run: got %b want 0", counts[i], bus.cpu_run); end
      n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL badcnt%0d writes: got %0d want 0", counts[i], obs_q.size()); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int waited = 0;
    obs_q.delete();
    random_words(2);
    pulse_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h02, 0, ok);
    send_byte(tx_words[0][31:24], 0, ok);
    send_byte(tx_words[0][23:16], 0, ok);
    drop_valid();
    repeat (1000) @(negedge CLK);
    n_cmp++; if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL timeout_early: busy=%b error=%b want busy=1 error=0", bus.busy, bus.error); end
    while (bus.error !== 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    n_cmp++; if (waited !== 24) begin n_bad++; $display("FAIL timeout_latency: error after %0d more cycles, want 24", waited); end
    n_cmp++; if (bus.err_code !== 2'b11) begin n_bad++; $display("FAIL timeout err_code: got %b want 11", bus.err_code); end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL timeout writes: got %0d want 0", obs_q.size()); end
    random_words(3);
    build_exp(3);
    send_frame(3, model_csum(3), 1);
    n_cmp++; if (bus.cpu_run !== 1'b1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL timeout_recover: cpu_run=%b error=%b want 1/0", bus.cpu_run, bus.error); end
    n_cmp++; if (obs_q !== exp_q) begin n_bad++; $display("FAIL timeout_recover writes: got %0d entries, want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    logic [31:0] w;
    random_words(3);
    pulse_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h03, 0, ok);
    for (int k = 0; k < 6; k++) begin
      w = tx_words[k / 4];
      send_byte(w[31 - 8 * (k % 4) -: 8], 0, ok);
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    obs_q.delete();
    @(negedge CLK);
    n_cmp++; if (bus.dbg_state !== 3'd0) begin n_bad++; $display("FAIL rst_mid state: got %0d want 0 (idle)", bus.dbg_state); end
    n_cmp++; if ({bus.in_ready, bus.imem_we, bus.cpu_run, bus.busy, bus.error, bus.err_code} !== 7'd0) begin n_bad++; $display("FAIL rst_mid flags: got %b want 0", {bus.in_ready, bus.imem_we, bus.cpu_run, bus.busy, bus.error, bus.err_code}); end
    n_cmp++; if ({bus.imem_addr, bus.imem_wdata, bus.words_loaded} !== 80'd0) begin n_bad++; $display("FAIL rst_mid regs: got addr %h data %h words %0d want 0", bus.imem_addr, bus.imem_wdata, bus.words_loaded); end
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'($urandom);
      @(negedge CLK);
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid ignore%0d: in_ready=%b busy=%b want 0/0", i, bus.in_ready, bus.busy); end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (obs_q.size() !== 0 || bus.words_loaded !== 16'd0) begin n_bad++; $display("FAIL rst_mid writes: got %0d words %0d want 0", obs_q.size(), bus.words_loaded); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] w;
    random_words(4);
    build_exp(4);
    obs_q.delete();
    obs_cyc.delete();
    pulse_start();
    stalls = 0;
    send_byte(8'h00, 0, ok);
    send_byte(8'h04, 0, ok);
    for (int i = 0; i < 4; i++) begin
      w = tx_words[i];
      for (int k = 0; k < 4; k++) send_byte(w[31 - 8 * k -: 8], 0, ok);
    end
    send_byte(model_csum(4), 0, ok);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.cpu_run !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b done: cpu_run=%b busy=%b want 1/0 one cycle after csum", bus.cpu_run, bus.busy); end
    n_cmp++; if (stalls !== 0) begin n_bad++; $display("FAIL b2b stalls: got %0d want 0", stalls); end
    n_cmp++; if (obs_q !== exp_q) begin n_bad++; $display("FAIL b2b writes: got %0d entries, want %0d matching", obs_q.size(), exp_q.size()); end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_cmp++; if (obs_cyc[i] - obs_cyc[i - 1] !== 4) begin n_bad++; $display("FAIL b2b spacing%0d: got %0d want 4", i, obs_cyc[i] - obs_cyc[i - 1]); end
    end
    // start in DONE drops cpu_run on the next cycle
    pulse_start();
    n_cmp++; if (bus.cpu_run !== 1'b0 || bus.busy !== 1'b1 || bus.words_loaded !== 16'd0) begin n_bad++; $display("FAIL restart: cpu_run=%b busy=%b words=%0d want 0/1/0", bus.cpu_run, bus.busy, bus.words_loaded); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    test_reset();
    test_frames();
    test_bad_count();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
